// File: rtl/decoded_register_bank.sv
// decoded_register_bank: 4-entry register bank written through one-hot select
// lines (driven by a 2-to-4 decoder). A write is staged for one cycle and then
// committed. Both read ports bypass from the staged write, so the data is
// readable right after the staging edge.
// Optional build macro: ONEHOT_CHECK_EN rejects multi-hot selects and flags
// them in the sticky sel_err output. Without it, a multi-hot select writes
// every selected entry.
module decoded_register_bank #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wsel0,
  input  logic             wsel1,
  input  logic             wsel2,
  input  logic             wsel3,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       ra_addr,
  input  logic [1:0]       rb_addr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             pend_vld,
  output logic [7:0]       wr_count,
  output logic             sel_err
);
  localparam int N = 4;

  logic [N-1:0]            wsel;
  logic [N-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [N-1:0]            pend_sel_q, pend_sel_d;
  logic [WIDTH-1:0]        pend_data_q, pend_data_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [7:0]              wr_count_q, wr_count_d;
  logic                    sel_err_q, sel_err_d;
  logic                    accept;

  assign wsel = {wsel3, wsel2, wsel1, wsel0};

`ifdef ONEHOT_CHECK_EN
  logic multi_hot;
  // More than one select bit set: clearing the lowest set bit leaves something.
  assign multi_hot = |(wsel & (wsel - 4'd1));
  assign accept    = (|wsel) & ~multi_hot;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign accept         = |wsel;
`endif

  // Next-state: commit the staged write, stage the incoming one, count and flag.
  always_comb begin
    regs_d      = regs_q;
    pend_sel_d  = wsel;
    pend_data_d = wr_data;
    pend_vld_d  = accept;
    wr_count_d  = wr_count_q;
    sel_err_d   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pend_vld_q && pend_sel_q[i]) regs_d[i] = pend_data_q;
    end
    if (accept) wr_count_d = wr_count_q + 8'd1;
`ifdef ONEHOT_CHECK_EN
    // A new error on the same edge as err_clr takes priority and stays set.
    sel_err_d = sel_err_q;
    if (err_clr)   sel_err_d = 1'b0;
    if (multi_hot) sel_err_d = 1'b1;
`endif
  end

  // State registers; reset drops any pending write without committing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q      <= '0;
      pend_sel_q  <= '0;
      pend_data_q <= '0;
      pend_vld_q  <= 1'b0;
      wr_count_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      pend_sel_q  <= pend_sel_d;
      pend_data_q <= pend_data_d;
      pend_vld_q  <= pend_vld_d;
      wr_count_q  <= wr_count_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Read ports: the staged write shadows the committed register for its entry.
  always_comb begin
    ra_data = (pend_vld_q && pend_sel_q[ra_addr]) ? pend_data_q : regs_q[ra_addr];
    rb_data = (pend_vld_q && pend_sel_q[rb_addr]) ? pend_data_q : regs_q[rb_addr];
  end

  assign pend_vld = pend_vld_q;
  assign wr_count = wr_count_q;
  assign sel_err  = sel_err_q;
endmodule
